// File: rtl/aes_inv_cipher_iter.sv
`default_nettype none
// ============================================================================
// Module  : aes_inv_cipher_iter
// Brief   : Iterative AES-128 inverse cipher, one round per clock; round keys
//           are read from an external key-schedule RAM (addresses 10 down to 0).
//           Define AES_INV_DEBUG_EN to add dbg_round/dbg_state and a key X check.
// Revision: 1.0 - initial release
// ============================================================================
module aes_inv_cipher_iter #(
    parameter int N       = 127,
    parameter int NR      = 10,
    parameter int KADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N:0]         cipher_in,
    output logic               key_rd_en,
    output logic [KADDR_W-1:0] key_rd_addr,
    input  logic [N:0]         key_rd_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N:0]         plain_out
`ifdef AES_INV_DEBUG_EN
    ,
    output logic [3:0]         dbg_round,
    output logic [N:0]         dbg_state
`endif
);

    localparam int NB = (N + 1) / 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WHITEN = 3'd2,
        S_ROUND  = 3'd3,
        S_FINAL  = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    localparam logic [2047:0] INV_SBOX = {
        256'h52096ad53036a538bf40a39e81f3d7fb_7ce339829b2fff87348e4344c4dee9cb,
        256'h547b9432a6c2233dee4c950b42fac34e_082ea16628d924b2765ba2496d8bd125,
        256'h72f8f66486689816d4a45ccc5d65b692_6c704850fdedb9da5e154657a78d9d84,
        256'h90d8ab008cbcd30af7e45805b8b34506_d02c1e8fca3f0f02c1afbd0301138a6b,
        256'h3a9111414f67dcea97f2cfcef0b4e673_96ac7422e7ad3585e2f937e81c75df6e,
        256'h47f11a711d29c5896fb7620eaa18be1b_fc563e4bc6d279209adbc0fe78cd5af4,
        256'h1fdda8338807c731b11210592780ec5f_60517fa919b54a0d2de57a9f93c99cef,
        256'ha0e03b4dae2af5b0c8ebbb3c83539961_172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiples 9, b, d, e are built from x2/x4/x8 so no GF multiplier is needed.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a, x2, x4, x8;
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int k = 0; k < 4; k++) begin
            a     = col[31-8*k -: 8];
            x2    = xtime(a);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[k] = x8 ^ a;
            mb[k] = x8 ^ x2 ^ a;
            md[k] = x8 ^ x4 ^ a;
            me[k] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    state_e             state_q, state_d;
    logic [3:0]         round_q, round_d;
    logic [N:0]         st_q, st_d;
    logic               in_ready_q, in_ready_d;
    logic               key_rd_en_q, key_rd_en_d;
    logic [KADDR_W-1:0] key_rd_addr_q, key_rd_addr_d;
    logic               out_valid_q, out_valid_d;
    logic [N:0]         plain_out_q, plain_out_d;

    logic [N:0]         w_shift, w_sub, w_ark, w_mix;

    // Byte i sits at row i%4, column i/4; InvShiftRows pulls row r from column c-r.
    for (genvar i = 0; i < NB; i++) begin : g_byte
        localparam int ROW = i % 4;
        localparam int COL = i / 4;
        localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
        assign w_shift[N-8*i -: 8] = st_q[N-8*SRC -: 8];
        assign w_sub[N-8*i -: 8]   = inv_sbox(w_shift[N-8*i -: 8]);
    end

    assign w_ark = w_sub ^ key_rd_data;

    for (genvar c = 0; c < NB / 4; c++) begin : g_col
        assign w_mix[N-32*c -: 32] = inv_mix_col(w_ark[N-32*c -: 32]);
    end

    always_comb begin
        state_d       = state_q;
        round_d       = round_q;
        st_d          = st_q;
        key_rd_en_d   = 1'b0;
        key_rd_addr_d = key_rd_addr_q;
        out_valid_d   = 1'b0;
        plain_out_d   = plain_out_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    st_d          = cipher_in;
                    state_d       = S_FETCH;
                    round_d       = 4'(NR);
                    key_rd_en_d   = 1'b1;
                    key_rd_addr_d = KADDR_W'(NR);
                end
            end
            S_FETCH: begin
                state_d       = S_WHITEN;
                key_rd_en_d   = 1'b1;
                key_rd_addr_d = key_rd_addr_q - KADDR_W'(1);
            end
            S_WHITEN: begin
                st_d          = st_q ^ key_rd_data;
                state_d       = S_ROUND;
                round_d       = round_q - 4'd1;
                key_rd_en_d   = 1'b1;
                key_rd_addr_d = key_rd_addr_q - KADDR_W'(1);
            end
            S_ROUND: begin
                st_d    = w_mix;
                round_d = round_q - 4'd1;
                if (round_q == 4'd1) begin
                    state_d = S_FINAL;
                end else begin
                    key_rd_en_d   = 1'b1;
                    key_rd_addr_d = key_rd_addr_q - KADDR_W'(1);
                end
            end
            S_FINAL: begin
                st_d        = w_ark;
                plain_out_d = w_ark;
                state_d     = S_DONE;
                round_d     = 4'hF;
                out_valid_d = 1'b1;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                round_d = 4'hF;
            end
        endcase
        in_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            round_q       <= 4'hF;
            st_q          <= '0;
            in_ready_q    <= 1'b0;
            key_rd_en_q   <= 1'b0;
            key_rd_addr_q <= '0;
            out_valid_q   <= 1'b0;
            plain_out_q   <= '0;
        end else begin
            state_q       <= state_d;
            round_q       <= round_d;
            st_q          <= st_d;
            in_ready_q    <= in_ready_d;
            key_rd_en_q   <= key_rd_en_d;
            key_rd_addr_q <= key_rd_addr_d;
            out_valid_q   <= out_valid_d;
            plain_out_q   <= plain_out_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign key_rd_en   = key_rd_en_q;
    assign key_rd_addr = key_rd_addr_q;
    assign out_valid   = out_valid_q;
    assign plain_out   = plain_out_q;

`ifdef AES_INV_DEBUG_EN
    assign dbg_round = round_q;
    assign dbg_state = st_q;

    always_ff @(posedge clk) begin
        if (rst_n && (state_q == S_WHITEN || state_q == S_ROUND || state_q == S_FINAL)
            && $isunknown(key_rd_data)) begin
            $error("aes_inv_cipher_iter: key_rd_data is X in the cycle it is consumed");
        end
    end
`endif

endmodule
`default_nettype wire
